// File: rtl/collision_scanner_if.sv
// Bus bundle between the game core and the collision scanner.
// The master side drives the frame snapshot inputs; the slave side is the scanner.
interface collision_scanner_if #(
    parameter int N_TUBES = 3,
    parameter int POS_W   = 10,
    parameter int SCORE_W = 8,
    parameter int CT_W    = $clog2(N_TUBES + 1)
);
    logic                       frame_tick;
    logic [POS_W-1:0]           bird_y_pos;
    logic [N_TUBES*POS_W-1:0]   tube_x_pos;
    logic [N_TUBES*POS_W-1:0]   tube_y_pos;
    logic                       busy;
    logic                       check_done;
    logic                       game_end;
    logic [CT_W-1:0]            crash_tube;
    logic [SCORE_W-1:0]         score;
    logic                       overrun;

    modport master (
        output frame_tick, bird_y_pos, tube_x_pos, tube_y_pos,
        input  busy, check_done, game_end, crash_tube, score, overrun
    );

    modport slave (
        input  frame_tick, bird_y_pos, tube_x_pos, tube_y_pos,
        output busy, check_done, game_end, crash_tube, score, overrun
    );
endinterface

// File: rtl/collision_scanner.sv
// Sequential bird-vs-tube collision and scoring engine: snapshots one frame, scans one tube
// per clock through a shared comparator set, then commits score or latches a sticky crash.
//
// state   | meaning
// IDLE    | waiting for frame_tick; snapshot and bounds check on tick
// SCAN    | evaluating tube idx_q, one per clock
// DONE    | check_done pulse; commit score or go to CRASHED
// CRASHED | game over; holds until clr
module collision_scanner #(
    parameter int N_TUBES     = 3,
    parameter int POS_W       = 10,
    parameter int BIRD_X      = 180,
    parameter int BIRD_HALF   = 15,
    parameter int TUBE_HALF_W = 30,
    parameter int GAP_HALF    = 35,
    parameter int SCREEN_H    = 480,
    parameter int SCORE_W     = 8
) (
    input logic                clk,
    input logic                clr,
    collision_scanner_if.slave bus
);
    localparam int W      = POS_W + 2;
    localparam int CT_W   = $clog2(N_TUBES + 1);
    localparam int IDX_W  = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;
    localparam int PEND_W = $clog2(N_TUBES + 1);
    localparam int SUM_W  = ((SCORE_W > PEND_W) ? SCORE_W : PEND_W) + 1;

    localparam logic [W-1:0] C_BH   = W'(BIRD_HALF);
    localparam logic [W-1:0] C_GH   = W'(GAP_HALF);
    localparam logic [W-1:0] C_SH   = W'(SCREEN_H);
    localparam logic [W-1:0] C_BX   = W'(BIRD_X);
    localparam logic [W-1:0] C_TB   = W'(TUBE_HALF_W + BIRD_HALF);
    localparam logic [W-1:0] C_XR   = W'(BIRD_X + BIRD_HALF + TUBE_HALF_W);
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_TUBES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_DONE    = 2'd2,
        S_CRASHED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [W-1:0]        by_q;
    logic [POS_W-1:0]    tx_q [N_TUBES];
    logic [POS_W-1:0]    ty_q [N_TUBES];
    logic [N_TUBES-1:0]  passed_q;
    logic                hit_q;
    logic [CT_W-1:0]     crash_tube_q;
    logic [PEND_W-1:0]   pend_q;
    logic [SCORE_W-1:0]  score_q;
    logic                overrun_q;

    logic snap, scan_en, commit, overrun_set;
    logic [W-1:0] by_live, tx_sel, ty_sel;
    logic bounds_live, y_hit, x_hit, tube_hit, tube_passed;
    logic [SUM_W-1:0] score_sum;
    logic [SCORE_W-1:0] score_sat;

    // Bounds are judged on the live bird position at the moment of the snapshot.
    assign by_live     = {2'b00, bus.bird_y_pos};
    assign bounds_live = (by_live < C_BH) | (by_live + C_BH >= C_SH);

    assign tx_sel = {2'b00, tx_q[idx_q]};
    assign ty_sel = {2'b00, ty_q[idx_q]};

    // Offsets sit on the adding side of every compare, so nothing wraps.
    assign y_hit       = (by_q + C_BH >= ty_sel + C_GH) | (by_q + C_GH <= ty_sel + C_BH);
    assign x_hit       = (C_XR >= tx_sel) & (C_BX <= tx_sel + C_TB);
    assign tube_hit    = x_hit & y_hit;
    assign tube_passed = (tx_sel + C_TB < C_BX);

    assign score_sum = SUM_W'(score_q) + SUM_W'(pend_q);
    assign score_sat = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snap        = 1'b0;
        scan_en     = 1'b0;
        commit      = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_tick) begin
                    snap    = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                scan_en     = 1'b1;
                overrun_set = bus.frame_tick;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                overrun_set = bus.frame_tick;
                commit      = ~hit_q;
                state_d     = hit_q ? S_CRASHED : S_IDLE;
            end
            S_CRASHED: begin
                state_d = S_CRASHED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            idx_q        <= '0;
            by_q         <= '0;
            passed_q     <= '0;
            hit_q        <= 1'b0;
            crash_tube_q <= '0;
            pend_q       <= '0;
            score_q      <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < N_TUBES; i++) begin
                tx_q[i] <= '0;
                ty_q[i] <= '0;
            end
        end else begin
            if (snap) begin
                by_q         <= by_live;
                idx_q        <= '0;
                hit_q        <= bounds_live;
                crash_tube_q <= bounds_live ? CT_W'(N_TUBES) : '0;
                pend_q       <= '0;
                for (int i = 0; i < N_TUBES; i++) begin
                    tx_q[i] <= bus.tube_x_pos[i*POS_W +: POS_W];
                    ty_q[i] <= bus.tube_y_pos[i*POS_W +: POS_W];
                end
            end
            if (scan_en) begin
                idx_q <= idx_q + 1'b1;
                // Only the first hit of the frame names the crash source.
                if (tube_hit && !hit_q) begin
                    hit_q        <= 1'b1;
                    crash_tube_q <= CT_W'(idx_q);
                end
                passed_q[idx_q] <= tube_passed;
                if (tube_passed && !passed_q[idx_q]) begin
                    pend_q <= pend_q + 1'b1;
                end
            end
            if (commit) begin
                score_q <= score_sat;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.busy       = (state_q == S_SCAN) | (state_q == S_DONE);
    assign bus.check_done = (state_q == S_DONE);
    assign bus.game_end   = (state_q == S_CRASHED) | ((state_q == S_DONE) & hit_q);
    assign bus.crash_tube = crash_tube_q;
    assign bus.score      = score_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: directed frames plus randomized frames
// checked against a frame-level arithmetic model of the collision and scoring rules.
module tb_collision_scanner;
    localparam int NA = 3;
    localparam int NB = 1;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    collision_scanner_if #(.N_TUBES(NA), .POS_W(10), .SCORE_W(8)) ifa ();
    collision_scanner_if #(.N_TUBES(NB), .POS_W(10), .SCORE_W(2)) ifb ();

    collision_scanner #(.N_TUBES(NA), .SCORE_W(8)) dut_a (.clk(clk), .clr(clr), .bus(ifa.slave));
    collision_scanner #(.N_TUBES(NB), .SCORE_W(2)) dut_b (.clk(clk), .clr(clr), .bus(ifb.slave));

    int checks   = 0;
    int failures = 0;

    int cur_by;
    int cur_tx [NA];
    int cur_ty [NA];

    int m_score;
    bit m_passed [NA];
    bit m_crashed;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_score   = 0;
        m_crashed = 1'b0;
        for (int i = 0; i < NA; i++) m_passed[i] = 1'b0;
    endtask

    task automatic drive_a();
        ifa.bird_y_pos = 10'(cur_by);
        for (int i = 0; i < NA; i++) begin
            ifa.tube_x_pos[i*10 +: 10] = 10'(cur_tx[i]);
            ifa.tube_y_pos[i*10 +: 10] = 10'(cur_ty[i]);
        end
    endtask

    // Full frame on dut_a: model prediction, tick, latency/busy, result and score checks.
    task automatic run_frame_a(input string tag);
        int  exp_ct, pend, cyc;
        bit  exp_crash;
        exp_crash = 1'b0;
        exp_ct    = 0;
        pend      = 0;
        if (cur_by < 15 || cur_by + 15 >= 480) begin
            exp_crash = 1'b1;
            exp_ct    = NA;
        end
        for (int i = 0; i < NA; i++) begin
            bit yh, xh, p;
            yh = (cur_by + 15 >= cur_ty[i] + 35) || (cur_by + 35 <= cur_ty[i] + 15);
            xh = (cur_tx[i] <= 225) && (cur_tx[i] + 45 >= 180);
            if (xh && yh && !exp_crash) begin
                exp_crash = 1'b1;
                exp_ct    = i;
            end
            p = (cur_tx[i] + 45 < 180);
            if (p && !m_passed[i]) pend++;
            m_passed[i] = p;
        end
        if (!exp_crash) m_score = (m_score + pend > 255) ? 255 : m_score + pend;

        @(negedge clk);
        drive_a();
        ifa.frame_tick = 1'b1;
        @(negedge clk);
        ifa.frame_tick = 1'b0;
        ifa.bird_y_pos = 10'($urandom_range(0, 1023));
        ifa.tube_x_pos = 30'($urandom);
        ifa.tube_y_pos = 30'($urandom);
        cyc = 1;
        while (ifa.check_done !== 1'b1 && cyc <= 12) begin
            checks++;
            if (ifa.busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy_during_scan cyc=%0d got=%b exp=1", tag, cyc, ifa.busy);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== NA + 1) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, NA + 1);
        end
        checks++;
        if (ifa.busy !== 1'b1 || ifa.game_end !== exp_crash) begin
            failures++;
            $display("FAIL %s done_cycle busy=%b game_end=%b exp busy=1 game_end=%b",
                     tag, ifa.busy, ifa.game_end, exp_crash);
        end
        if (exp_crash) begin
            checks++;
            if (ifa.crash_tube !== 2'(exp_ct)) begin
                failures++;
                $display("FAIL %s crash_tube got=%0d exp=%0d", tag, ifa.crash_tube, exp_ct);
            end
        end
        @(negedge clk);
        checks++;
        if (ifa.check_done !== 1'b0 || ifa.score !== 8'(m_score) || ifa.game_end !== exp_crash
            || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done done=%b score=%0d game_end=%b busy=%b exp done=0 score=%0d game_end=%b busy=0",
                     tag, ifa.check_done, ifa.score, ifa.game_end, ifa.busy, m_score, exp_crash);
        end
        m_crashed = exp_crash;
    endtask

    task automatic set_frame(input int by, input int x0, input int x1, input int x2, input int ty);
        cur_by = by;
        cur_tx[0] = x0; cur_tx[1] = x1; cur_tx[2] = x2;
        for (int i = 0; i < NA; i++) cur_ty[i] = ty;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (ifa.busy !== 1'b0 || ifa.check_done !== 1'b0 || ifa.game_end !== 1'b0 ||
            ifa.crash_tube !== 2'd0 || ifa.score !== 8'd0 || ifa.overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s outputs busy=%b done=%b ge=%b ct=%0d score=%0d ovr=%b exp all 0",
                     tag, ifa.busy, ifa.check_done, ifa.game_end, ifa.crash_tube, ifa.score, ifa.overrun);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        check_all_zero("reset_a");
        checks++;
        if (ifb.busy !== 1'b0 || ifb.score !== 2'd0 || ifb.game_end !== 1'b0 || ifb.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_b busy=%b score=%0d ge=%b ovr=%b exp 0", ifb.busy, ifb.score, ifb.game_end, ifb.overrun);
        end
        do_clr();
    endtask

    task automatic test_nominal();
        set_frame(240, 600, 800, 1000, 240);
        run_frame_a("nominal");
    endtask

    task automatic test_tube_crash();
        set_frame(200, 600, 180, 1000, 240);
        run_frame_a("tube1_crash");
        @(negedge clk);
        ifa.frame_tick = 1'b1;
        @(negedge clk);
        ifa.frame_tick = 1'b0;
        repeat (6) begin
            checks++;
            if (ifa.busy !== 1'b0 || ifa.check_done !== 1'b0 || ifa.game_end !== 1'b1 ||
                ifa.overrun !== 1'b0 || ifa.crash_tube !== 2'd1) begin
                failures++;
                $display("FAIL crashed_hold busy=%b done=%b ge=%b ovr=%b ct=%0d exp 0 0 1 0 1",
                         ifa.busy, ifa.check_done, ifa.game_end, ifa.overrun, ifa.crash_tube);
            end
            @(negedge clk);
        end
        do_clr();
        check_all_zero("clr_after_crash");
    endtask

    task automatic test_bounds();
        set_frame(10, 180, 800, 1000, 240);
        run_frame_a("ceiling_first");
        do_clr();
        set_frame(470, 600, 800, 1000, 240);
        run_frame_a("floor");
        do_clr();
    endtask

    task automatic test_scoring();
        set_frame(240, 140, 600, 800, 240);
        run_frame_a("score_140");
        cur_tx[0] = 130; run_frame_a("score_130");
        cur_tx[0] = 120; run_frame_a("score_120");
        cur_tx[0] = 900; run_frame_a("score_900");
        cur_tx[0] = 130; run_frame_a("score_130b");
        checks++;
        if (ifa.score !== 8'd2) begin
            failures++;
            $display("FAIL score_sequence got=%0d exp=2", ifa.score);
        end
        do_clr();
    endtask

    task automatic test_overrun();
        set_frame(240, 600, 800, 1000, 240);
        @(negedge clk);
        drive_a();
        ifa.frame_tick = 1'b1;
        @(negedge clk);
        ifa.frame_tick = 1'b0;
        @(negedge clk);
        ifa.frame_tick = 1'b1;
        @(negedge clk);
        ifa.frame_tick = 1'b0;
        checks++;
        if (ifa.overrun !== 1'b1 || ifa.busy !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set ovr=%b busy=%b exp 1 1", ifa.overrun, ifa.busy);
        end
        @(negedge clk);
        checks++;
        if (ifa.check_done !== 1'b1) begin
            failures++;
            $display("FAIL overrun_latency done=%b exp=1", ifa.check_done);
        end
        @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b0 || ifa.check_done !== 1'b0 || ifa.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_dropped busy=%b done=%b ovr=%b exp 0 0 1", ifa.busy, ifa.check_done, ifa.overrun);
        end
        do_clr();
        check_all_zero("overrun_cleared");
    endtask

    task automatic test_clr_mid_scan();
        bit seen;
        set_frame(240, 130, 800, 1000, 240);
        @(negedge clk);
        drive_a();
        ifa.frame_tick = 1'b1;
        @(negedge clk);
        ifa.frame_tick = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_all_zero("clr_mid_scan");
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.check_done === 1'b1 || ifa.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL clr_abort got activity=%b exp=0", seen);
        end
        do_clr();
    endtask

    task automatic test_random();
        for (int f = 0; f < 120; f++) begin
            cur_by = (f % 9 == 0) ? $urandom_range(0, 1023) : $urandom_range(15, 470);
            for (int i = 0; i < NA; i++) begin
                cur_tx[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 240) : $urandom_range(0, 1023);
                cur_ty[i] = $urandom_range(0, 480);
            end
            run_frame_a($sformatf("rand%0d", f));
            if (m_crashed) do_clr();
        end
        do_clr();
    endtask

    task automatic test_narrow();
        int sb;
        bit pb;
        int cyc;
        sb = 0;
        pb = 1'b0;
        for (int f = 0; f < 8; f++) begin
            int tx;
            bit p;
            tx = (f % 2 == 0) ? 900 : 130;
            p  = (tx + 45 < 180);
            if (p && !pb) sb = (sb + 1 > 3) ? 3 : sb + 1;
            pb = p;
            @(negedge clk);
            ifb.bird_y_pos = 10'd240;
            ifb.tube_x_pos = 10'(tx);
            ifb.tube_y_pos = 10'd240;
            ifb.frame_tick = 1'b1;
            @(negedge clk);
            ifb.frame_tick = 1'b0;
            cyc = 1;
            while (ifb.check_done !== 1'b1 && cyc <= 8) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc !== NB + 1) begin
                failures++;
                $display("FAIL narrow_latency f=%0d got=%0d exp=%0d", f, cyc, NB + 1);
            end
            @(negedge clk);
            checks++;
            if (ifb.score !== 2'(sb) || ifb.game_end !== 1'b0) begin
                failures++;
                $display("FAIL narrow_score f=%0d got=%0d ge=%b exp=%0d ge=0", f, ifb.score, ifb.game_end, sb);
            end
        end
        checks++;
        if (ifb.score !== 2'd3) begin
            failures++;
            $display("FAIL narrow_saturate got=%0d exp=3", ifb.score);
        end
    endtask

    initial begin
        clr = 1'b1;
        ifa.frame_tick = 1'b0; ifa.bird_y_pos = '0; ifa.tube_x_pos = '0; ifa.tube_y_pos = '0;
        ifb.frame_tick = 1'b0; ifb.bird_y_pos = '0; ifb.tube_x_pos = '0; ifb.tube_y_pos = '0;
        m_score = 0;
        m_crashed = 1'b0;
        for (int i = 0; i < NA; i++) m_passed[i] = 1'b0;
        test_reset();
        test_nominal();
        do_clr();
        test_tube_crash();
        test_bounds();
        test_scoring();
        test_overrun();
        test_clr_mid_scan();
        test_random();
        test_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
